otter_cu_fsm: RTL and testbench

// Multicycle sequencer for the Otter core. Steps each instruction through FETCH/EXEC/(WB)/(INTR) and drives all

---
 rtl/otter_cu_fsm_pkg.sv | 47 ++++
 rtl/otter_cu_fsm_intr_sync.sv | 33 +++
 rtl/otter_cu_fsm.sv | 143 ++++++++++++++
 tb/tb_otter_cu_fsm.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_cu_fsm_pkg.sv
// Shared Otter opcode constants, FSM state encodings and the strobe bundle.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package otter_cu_fsm_pkg;

    // Opcode constants are the same values the combinational decoder uses.
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } cu_state_e;

    typedef struct packed {
        logic core_reset;
        logic pc_write;
        logic rf_write;
        logic imem_rden;
        logic dmem_rden;
        logic dmem_we;
        logic csr_we;
        logic int_taken;
        logic mret_exec;
    } cu_strobe_t;

    // Instructions that write rd and advance the PC in a single EXEC cycle.
    function automatic logic is_rf_pc_op(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LUI) ||
               (op == OP_AUIPC) || (op == OP_JAL)   || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/otter_cu_fsm_intr_sync.sv
// Synchronises the asynchronous interrupt level and emits a 1-cycle pulse on its rising edge.
// Latency: pulse is high SYNC_STAGES cycles after the first clock edge that samples intr_req high.
// Backpressure: none; a level held high produces exactly one pulse.
module otter_cu_fsm_intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic intr_req,
    output logic intr_pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_prev_q, lvl_prev_d;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], intr_req};
        lvl_prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            lvl_prev_q <= lvl_prev_d;
        end
    end

    assign intr_pulse = sync_q[SYNC_STAGES-1] & ~lvl_prev_q;

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle Otter sequencer: INIT/FETCH/EXEC/WB/INTR with Mealy strobes for PC, RF, CSR and memories.
// Latency: 2 cycles per ALU/branch/system instruction, 3+ for loads and stalled stores, +1 for a trap.
// Backpressure: FETCH waits on imem_ready, stores and WB wait on dmem_ready; nothing commits while waiting.
module otter_cu_fsm
    import otter_cu_fsm_pkg::*;
#(
    parameter int INIT_CYCLES = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func,
    input  logic       intr_req,
    input  logic       mie,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       rf_write,
    output logic       imem_rden,
    output logic       dmem_rden,
    output logic       dmem_we,
    output logic       csr_we,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       core_reset,
    output logic [2:0] state_dbg
);

    localparam int             CNT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

    cu_state_e        state_q, state_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic             intr_pend_q, intr_pend_d;
    logic             intr_pulse;
    logic             instr_done;
    cu_strobe_t       strb;

    otter_cu_fsm_intr_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_intr_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .intr_req   (intr_req),
        .intr_pulse (intr_pulse)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = '0;
        strb       = '0;
        instr_done = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                strb.core_reset = 1'b1;
                if (init_cnt_q == CNT_LAST) begin
                    state_d = ST_FETCH;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_FETCH: begin
                strb.imem_rden = 1'b1;
                if (imem_ready) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_rf_pc_op(opcode)) begin
                    strb.rf_write = 1'b1;
                    strb.pc_write = 1'b1;
                end else if (opcode == OP_BRANCH) begin
                    strb.pc_write = 1'b1;
                end else if (opcode == OP_LOAD) begin
                    strb.dmem_rden = 1'b1;
                    state_d        = ST_WB;
                end else if (opcode == OP_STORE) begin
                    strb.dmem_we  = 1'b1;
                    strb.pc_write = dmem_ready;
                end else if (opcode == OP_SYSTEM && func == F3_CSRRW) begin
                    strb.csr_we   = 1'b1;
                    strb.rf_write = 1'b1;
                    strb.pc_write = 1'b1;
                end else if (opcode == OP_SYSTEM && func == F3_MRET) begin
                    strb.mret_exec = 1'b1;
                    strb.pc_write  = 1'b1;
                end else begin
                    // Unsupported SYSTEM variants and unknown opcodes retire as NOPs.
                    strb.pc_write = 1'b1;
                end
                instr_done = strb.pc_write;
            end
            ST_WB: begin
                strb.dmem_rden = 1'b1;
                if (dmem_ready) begin
                    strb.rf_write = 1'b1;
                    strb.pc_write = 1'b1;
                    instr_done    = 1'b1;
                end
            end
            ST_INTR: begin
                strb.int_taken = 1'b1;
                strb.pc_write  = 1'b1;
                state_d        = ST_FETCH;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // mie is the pre-restore value on an mret completion, so a pending trap waits one instruction.
        if (instr_done) begin
            state_d = (intr_pend_q && mie) ? ST_INTR : ST_FETCH;
        end

        // A new edge arriving in the trap cycle must survive the clear.
        intr_pend_d = intr_pulse | (intr_pend_q & (state_q != ST_INTR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            intr_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            intr_pend_q <= intr_pend_d;
        end
    end

    assign core_reset = strb.core_reset;
    assign pc_write   = strb.pc_write;
    assign rf_write   = strb.rf_write;
    assign imem_rden  = strb.imem_rden;
    assign dmem_rden  = strb.dmem_rden;
    assign dmem_we    = strb.dmem_we;
    assign csr_we     = strb.csr_we;
    assign int_taken  = strb.int_taken;
    assign mret_exec  = strb.mret_exec;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm: per-cycle comparison against an instruction-level model plus literal checks.
module tb_otter_cu_fsm;

    localparam int INIT_CYCLES = 3;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] func = 3'd0;
    logic       intr_req = 1'b0;
    logic       mie = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       pc_write, rf_write, imem_rden, dmem_rden, dmem_we;
    logic       csr_we, int_taken, mret_exec, core_reset;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    otter_cu_fsm #(
        .INIT_CYCLES (INIT_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .func       (func),
        .intr_req   (intr_req),
        .mie        (mie),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .pc_write   (pc_write),
        .rf_write   (rf_write),
        .imem_rden  (imem_rden),
        .dmem_rden  (dmem_rden),
        .dmem_we    (dmem_we),
        .csr_we     (csr_we),
        .int_taken  (int_taken),
        .mret_exec  (mret_exec),
        .core_reset (core_reset),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- instruction-level model ----------------
    // Phases: 0 reset hold, 1 fetch, 2 execute, 3 load writeback, 4 trap entry.
    localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_CSR = 4, K_MRET = 5, K_NOP = 6;

    int m_ph = 0;
    int m_icnt = 0;
    bit m_pend = 1'b0;
    int m_cd = 0;
    bit m_prev_req = 1'b0;

    function automatic int kind_of(input logic [6:0] op, input logic [2:0] f);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return K_ALU;
            7'b1100011: return K_BR;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1110011: return (f == 3'b001) ? K_CSR : ((f == 3'b000) ? K_MRET : K_NOP);
            default:    return K_NOP;
        endcase
    endfunction

    function automatic bit retires(input int ph, input logic [6:0] op, input logic [2:0] f,
                                   input logic dr);
        int k;
        k = kind_of(op, f);
        if (ph == 2) return (k != K_LD) && (k != K_ST || dr);
        if (ph == 3) return dr;
        return 1'b0;
    endfunction

    // Bundle order: core_reset,pc,rf,imem_rden,dmem_rden,dmem_we,csr_we,int_taken,mret_exec,state[2:0]
    function automatic logic [11:0] m_out(input int ph, input logic [6:0] op, input logic [2:0] f,
                                          input logic dr);
        logic cr, pc, rf, ird, drd, we, cw, it, mr;
        int   k;
        {cr, pc, rf, ird, drd, we, cw, it, mr} = 9'b0;
        k = kind_of(op, f);
        case (ph)
            0: cr = 1'b1;
            1: ird = 1'b1;
            2: begin
                pc = retires(ph, op, f, dr);
                rf = (k == K_ALU) || (k == K_CSR);
                cw = (k == K_CSR);
                mr = (k == K_MRET);
                drd = (k == K_LD);
                we = (k == K_ST);
            end
            3: begin
                drd = 1'b1;
                pc  = dr;
                rf  = dr;
            end
            4: begin
                it = 1'b1;
                pc = 1'b1;
            end
            default: ;
        endcase
        return {cr, pc, rf, ird, drd, we, cw, it, mr, 3'(ph)};
    endfunction

    function automatic int m_next(input int ph, input int icnt, input bit pend, input bit ie,
                                  input logic [6:0] op, input logic [2:0] f,
                                  input logic ir, input logic dr);
        int after;
        after = (pend && ie) ? 4 : 1;
        case (ph)
            0: return (icnt + 1 >= INIT_CYCLES) ? 1 : 0;
            1: return ir ? 2 : 1;
            2: begin
                if (kind_of(op, f) == K_LD) return 3;
                return retires(ph, op, f, dr) ? after : 2;
            end
            3: return dr ? after : 3;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph       <= 0;
            m_icnt     <= 0;
            m_pend     <= 1'b0;
            m_cd       <= 0;
            m_prev_req <= 1'b0;
        end else begin
            m_prev_req <= intr_req;
            // A sampled rising edge becomes pending SYNC_STAGES edges later.
            if (intr_req && !m_prev_req) m_cd <= SYNC_STAGES;
            else if (m_cd > 0)           m_cd <= m_cd - 1;
            m_pend <= (m_cd == 1) || (m_pend && m_ph != 4);
            m_ph   <= m_next(m_ph, m_icnt, m_pend, mie, opcode, func, imem_ready, dmem_ready);
            m_icnt <= (m_ph == 0) ? m_icnt + 1 : 0;
        end
    end

    logic [11:0] obs, exp_v;
    assign obs = {core_reset, pc_write, rf_write, imem_rden, dmem_rden, dmem_we,
                  csr_we, int_taken, mret_exec, state_dbg};

    always @(negedge clk) begin
        #3;
        exp_v = m_out(m_ph, opcode, func, dmem_ready);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t got %b expected %b", $time, obs, exp_v);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic lit1(input string nm, input logic act, input logic expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s got %b expected %b", nm, act, expv);
        end
    endtask

    task automatic lit3(input string nm, input logic [2:0] act, input logic [2:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", nm, act, expv);
        end
    endtask

    localparam logic [6:0] T_OP [10] = '{7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                                         7'b1100111, 7'b1100011, 7'b1110011, 7'b1110011,
                                         7'b1110011, 7'b1111111};
    localparam logic [2:0] T_F  [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                         3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
    // Expected EXEC strobes {pc_write, rf_write, csr_we, mret_exec}.
    localparam logic [3:0] T_EXP[10] = '{4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
                                         4'b1000, 4'b1110, 4'b1001, 4'b1000, 4'b1000};

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] e;

        // Reset held for 5 cycles, then three INIT cycles.
        repeat (5) step();
        #3;
        lit1("rst_core_reset", core_reset, 1'b1);
        lit3("rst_state", state_dbg, 3'd0);
        lit1("rst_pc_write", pc_write, 1'b0);
        step(); rst_n = 1'b1;
        #3 lit1("init0_core_reset", core_reset, 1'b1);
        step(); #3 lit1("init1_core_reset", core_reset, 1'b1);
        step(); #3 lit1("init2_core_reset", core_reset, 1'b1);
        step(); #3 begin
            lit3("init_exit_state", state_dbg, 3'd1);
            lit1("init_exit_core_reset", core_reset, 1'b0);
        end

        // Two back-to-back ADDs.
        step(); imem_ready = 1'b1; opcode = 7'b0110011;
        #3 lit1("add_fetch_imem_rden", imem_rden, 1'b1);
        step(); #3 begin
            lit3("add_exec_state", state_dbg, 3'd2);
            lit1("add_exec_rf_write", rf_write, 1'b1);
            lit1("add_exec_pc_write", pc_write, 1'b1);
        end
        step(); #3 begin
            lit3("add_next_fetch", state_dbg, 3'd1);
            lit1("add_fetch_rf_write", rf_write, 1'b0);
        end
        step();

        // LW with two WB stalls and an interrupt pulse, mie=1.
        step(); opcode = 7'b0000011; dmem_ready = 1'b0; mie = 1'b1; intr_req = 1'b1;
        step(); #3 begin
            lit1("lw_exec_dmem_rden", dmem_rden, 1'b1);
            lit1("lw_exec_pc_write", pc_write, 1'b0);
        end
        step(); #3 begin
            lit3("lw_wb_state", state_dbg, 3'd3);
            lit1("lw_wb_stall_rf_write", rf_write, 1'b0);
        end
        step(); intr_req = 1'b0;
        step(); dmem_ready = 1'b1;
        #3 begin
            lit1("lw_wb_done_rf_write", rf_write, 1'b1);
            lit1("lw_wb_done_pc_write", pc_write, 1'b1);
        end
        step(); dmem_ready = 1'b0;
        #3 begin
            lit3("lw_trap_state", state_dbg, 3'd4);
            lit1("lw_trap_int_taken", int_taken, 1'b1);
            lit1("lw_trap_pc_write", pc_write, 1'b1);
        end

        // Interrupt latched while mie=0; SW with one-cycle dmem delay.
        step(); imem_ready = 1'b0; mie = 1'b0; intr_req = 1'b1;
        #3 lit3("trap_return_fetch", state_dbg, 3'd1);
        step(); step();
        step(); intr_req = 1'b0;
        step(); imem_ready = 1'b1; opcode = 7'b0100011; dmem_ready = 1'b0;
        step(); #3 begin
            lit1("sw_stall_dmem_we", dmem_we, 1'b1);
            lit1("sw_stall_pc_write", pc_write, 1'b0);
        end
        step(); dmem_ready = 1'b1;
        #3 begin
            lit1("sw_done_dmem_we", dmem_we, 1'b1);
            lit1("sw_done_pc_write", pc_write, 1'b1);
            lit1("sw_done_rf_write", rf_write, 1'b0);
        end
        step(); dmem_ready = 1'b0; opcode = 7'b0110011;
        #3 lit3("mie0_no_trap_sw", state_dbg, 3'd1);
        step();
        step(); mie = 1'b1; intr_req = 1'b1;
        #3 lit3("mie0_no_trap_add", state_dbg, 3'd1);
        step();
        step(); #3 lit3("mie1_trap_taken", state_dbg, 3'd4);

        // Edge lands in the trap cycle: pending survives and a second trap follows.
        step(); step();
        step(); #3 lit3("set_wins_second_trap", state_dbg, 3'd4);
        step(); step();
        step(); #3 lit3("level_high_one_trap_a", state_dbg, 3'd1);
        step();
        step(); intr_req = 1'b0;
        #3 lit3("level_high_one_trap_b", state_dbg, 3'd1);
        step();

        // Remaining EXEC-only instruction classes.
        for (int i = 0; i < 10; i++) begin
            step(); opcode = T_OP[i]; func = T_F[i];
            step();
            e = T_EXP[i];
            #3 begin
                lit3("tbl_state", state_dbg, 3'd2);
                lit1("tbl_pc_write", pc_write, e[3]);
                lit1("tbl_rf_write", rf_write, e[2]);
                lit1("tbl_csr_we", csr_we, e[1]);
                lit1("tbl_mret_exec", mret_exec, e[0]);
            end
        end

        // Reset during a store stall with an interrupt pending.
        step(); opcode = 7'b0100011; func = 3'b000; dmem_ready = 1'b0; mie = 1'b0; intr_req = 1'b1;
        step(); step();
        step(); intr_req = 1'b0;
        #1 lit1("stall_pre_reset_dmem_we", dmem_we, 1'b1);
        #1 rst_n = 1'b0;
        #1 begin
            lit1("stall_reset_dmem_we", dmem_we, 1'b0);
            lit1("stall_reset_core_reset", core_reset, 1'b1);
            lit3("stall_reset_state", state_dbg, 3'd0);
        end
        step(); step();
        step(); rst_n = 1'b1; mie = 1'b1; opcode = 7'b0110011; imem_ready = 1'b1;
        step(); step(); step(); step();
        step(); intr_req = 1'b1; imem_ready = 1'b0;
        #3 lit3("pend_cleared_by_reset", state_dbg, 3'd1);

        // Reset during the trap cycle.
        step(); step();
        step(); intr_req = 1'b0;
        step(); imem_ready = 1'b1;
        step();
        step();
        #1 lit1("intr_pre_reset_int_taken", int_taken, 1'b1);
        #1 rst_n = 1'b0;
        #1 begin
            lit1("intr_reset_int_taken", int_taken, 1'b0);
            lit1("intr_reset_pc_write", pc_write, 1'b0);
            lit3("intr_reset_state", state_dbg, 3'd0);
        end
        step(); step();
        step(); rst_n = 1'b1;
        step(); step(); step(); step();
        step(); #3 lit3("intr_reset_pend_cleared", state_dbg, 3'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
